// File: rtl/cordic_fixed_to_float_pipe.sv
// rtl/cordic_fixed_to_float_pipe.sv - three-stage Q1.20 fixed-point to IEEE-754 single converter
module cordic_fixed_to_float_pipe #(
    parameter int WIDTH     = 21,
    parameter int FRAC_BITS = 20
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             clk_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] fixed_in,
    output logic             out_valid,
    output logic [31:0]      result
);

    localparam int PW = $clog2(WIDTH);

    logic             s1_valid_q, s1_sign_q;
    logic [WIDTH-1:0] s1_mag_q;
    logic             s2_valid_q, s2_sign_q, s2_zero_q;
    logic [WIDTH-1:0] s2_mag_q;
    logic [PW-1:0]    s2_lead_q;
    logic             out_valid_q;
    logic [31:0]      result_q;

    logic [WIDTH-1:0] mag_d;
    logic [PW-1:0]    lead_d;
    logic [7:0]       exp_d;
    logic [WIDTH-1:0] frac_d;
    logic [5:0]       shamt_d;
    logic [22:0]      mant_d;
    logic [31:0]      pack_d;

    // -1.0 negates to 2^20, which still fits the unsigned magnitude
    assign mag_d = fixed_in[WIDTH-1] ? -fixed_in : fixed_in;

    always_comb begin
        lead_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_mag_q[i]) begin
                lead_d = PW'(i);
            end
        end
    end

    // Hidden bit dropped, remaining bits left-aligned into the 23-bit mantissa
    always_comb begin
        exp_d   = 8'(127 + int'(s2_lead_q) - FRAC_BITS);
        frac_d  = s2_mag_q & ~(WIDTH'(1) << s2_lead_q);
        shamt_d = 6'(23 - int'(s2_lead_q));
        mant_d  = 23'(64'(frac_d) << shamt_d);
        pack_d  = s2_zero_q ? 32'h0 : {s2_sign_q, exp_d, mant_d};
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_mag_q    <= '0;
            s2_lead_q   <= '0;
            out_valid_q <= 1'b0;
            result_q    <= 32'h0;
        end else if (clk_en) begin
            s1_valid_q  <= in_valid;
            s1_sign_q   <= fixed_in[WIDTH-1];
            s1_mag_q    <= mag_d;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sign_q;
            s2_zero_q   <= (s1_mag_q == '0);
            s2_mag_q    <= s1_mag_q;
            s2_lead_q   <= lead_d;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                result_q <= pack_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_cordic_fixed_to_float_pipe.sv
// tb/tb_cordic_fixed_to_float_pipe.sv - randomized bench with real-arithmetic reference model
module tb_cordic_fixed_to_float_pipe;

    logic        clock = 1'b0;
    logic        aclr, clk_en, in_valid;
    logic [20:0] fixed_in;
    logic        out_valid;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          en_cnt  = 0;
    logic        exp_ov  = 1'b0;
    logic [31:0] exp_res = 32'h0;

    cordic_fixed_to_float_pipe #(.WIDTH(21), .FRAC_BITS(20)) dut (
        .clock    (clock),
        .aclr     (aclr),
        .clk_en   (clk_en),
        .in_valid (in_valid),
        .fixed_in (fixed_in),
        .out_valid(out_valid),
        .result   (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Convert through a double and repack the fields as single precision
    function automatic logic [31:0] ref_float(input logic [20:0] f);
        real         r;
        logic [63:0] b;
        int          e;
        r = real'($signed(f)) / 1048576.0;
        if (r == 0.0) return 32'h0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    task automatic step(input logic en, input logic v, input logic [20:0] d, input logic rst);
        exp_t ent;
        aclr     = rst;
        clk_en   = en;
        in_valid = v;
        fixed_in = d;
        @(posedge clock);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_ov  = 1'b0;
            exp_res = 32'h0;
        end else if (en) begin
            en_cnt++;
            if (v) begin
                ent.val = ref_float(d);
                ent.due = en_cnt + 2;
                exp_q.push_back(ent);
            end
            exp_ov = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
                exp_ov  = 1'b1;
                exp_res = exp_q[0].val;
                void'(exp_q.pop_front());
            end
        end
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("result", result, exp_res);
    endtask

    task automatic conv(input string tag, input logic [20:0] d, input logic [31:0] want);
        step(1'b1, 1'b1, d, 1'b0);
        step(1'b1, 1'b0, 21'h0, 1'b0);
        step(1'b1, 1'b0, 21'h0, 1'b0);
        check({tag, "_valid"}, 32'(out_valid), 32'h1);
        check(tag, result, want);
    endtask

    logic [20:0] corner [6];

    initial begin
        corner[0] = 21'h000000; corner[1] = 21'h100000; corner[2] = 21'h000001;
        corner[3] = 21'h0FFFFF; corner[4] = 21'h1FFFFF; corner[5] = 21'h180000;

        step(1'b1, 1'b0, 21'h0, 1'b1);
        step(1'b0, 1'b1, 21'h080000, 1'b1);
        check("reset_ov", 32'(out_valid), 32'h0);
        check("reset_res", result, 32'h0);

        conv("half", 21'h080000, 32'h3F00_0000);
        conv("neg_one", 21'h100000, 32'hBF80_0000);
        conv("neg_half", 21'h180000, 32'hBF00_0000);
        conv("lsb", 21'h000001, 32'h3580_0000);
        conv("max", 21'h0FFFFF, 32'h3F7F_FFF0);

        // Zero, bubble, then 0.5
        step(1'b1, 1'b1, 21'h000000, 1'b0);
        step(1'b1, 1'b0, 21'h0, 1'b0);
        step(1'b1, 1'b1, 21'h080000, 1'b0);
        check("zero_ov", 32'(out_valid), 32'h1);
        check("zero_res", result, 32'h0);
        step(1'b1, 1'b0, 21'h0, 1'b0);
        check("bubble_ov", 32'(out_valid), 32'h0);
        step(1'b1, 1'b0, 21'h0, 1'b0);
        check("after_bubble", result, 32'h3F00_0000);

        // Stall with a sample sitting in S2
        step(1'b1, 1'b1, 21'h180000, 1'b0);
        step(1'b1, 1'b0, 21'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 21'h0FFFFF, 1'b0);
        check("stall_hold", result, 32'h3F00_0000);
        step(1'b1, 1'b0, 21'h0, 1'b0);
        check("stall_emerge_ov", 32'(out_valid), 32'h1);
        check("stall_emerge", result, 32'hBF00_0000);

        // Reset mid-flight drops everything in the pipe
        step(1'b1, 1'b1, 21'h040000, 1'b0);
        step(1'b1, 1'b1, 21'h020000, 1'b0);
        step(1'b1, 1'b1, 21'h010000, 1'b0);
        step(1'b1, 1'b1, 21'h008000, 1'b1);
        check("midrst_ov", 32'(out_valid), 32'h0);
        check("midrst_res", result, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 21'h0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            logic [20:0] d;
            d = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 21'($urandom);
            step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, d,
                 $urandom_range(0, 59) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 21'h0, 1'b0);
        check("drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
